// File: rtl/ls_safety_pkg.sv
// Shared encodings for the lockstep/safety support blocks.
// Channel state codes and the 2-bit per-channel control field values.
package ls_safety_pkg;

    localparam logic [1:0] LS_ST_IDLE  = 2'd0;
    localparam logic [1:0] LS_ST_COUNT = 2'd1;
    localparam logic [1:0] LS_ST_DONE  = 2'd2;

    localparam logic [1:0] LS_CTL_RUN   = 2'b00;
    localparam logic [1:0] LS_CTL_CLR   = 2'b01;
    localparam logic [1:0] LS_CTL_PAUSE = 2'b10;

endpackage

// File: rtl/ls_boot_seq_ch.sv
// One boot-wait channel: wait register, saturating counter, IDLE/COUNT/DONE FSM.
// done asserts wait_reg+1 cycles after COUNT entry; pause stalls the counter, never backpressured.
module ls_boot_seq_ch
    import ls_safety_pkg::*;
#(
    parameter int CNT_W      = 7,
    parameter int BOOT_WAIT  = 25,
    parameter int AUTO_START = 1,
    parameter int PERIODIC   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ctl,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] count,
    output logic             count_done,
    output logic             done_pulse,
    output logic             done_nxt
);

    localparam logic [1:0]       ST_RST   = (AUTO_START != 0) ? LS_ST_COUNT : LS_ST_IDLE;
    localparam logic [CNT_W-1:0] WAIT_RST = CNT_W'(BOOT_WAIT);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_reg;
    logic             clr;
    logic             pause;
    logic             hit;

    assign clr   = (ctl == LS_CTL_CLR);
    assign pause = (ctl == LS_CTL_PAUSE);
    assign hit   = (state == LS_ST_COUNT) && !pause && (count >= wait_reg);

    // Exposed so the top can register all_done in the same cycle count_done rises.
    assign done_nxt = !clr && (hit || ((state == LS_ST_DONE) && (PERIODIC == 0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RST;
            count      <= '0;
            wait_reg   <= WAIT_RST;
            count_done <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            if (cfg_we) begin
                wait_reg <= cfg_wdata;
            end
            count_done <= done_nxt;
            done_pulse <= !clr && hit;
            if (clr) begin
                count <= '0;
                state <= ST_RST;
            end else begin
                case (state)
                    LS_ST_IDLE: begin
                        count <= '0;
                        if (start) begin
                            state <= LS_ST_COUNT;
                        end
                    end
                    LS_ST_COUNT: begin
                        if (!pause) begin
                            if (count >= wait_reg) begin
                                state <= LS_ST_DONE;
                            end else begin
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    LS_ST_DONE: begin
                        if (PERIODIC != 0) begin
                            count <= '0;
                            state <= LS_ST_COUNT;
                        end
                    end
                    default: begin
                        count <= '0;
                        state <= ST_RST;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ls_boot_seq.sv
// Multi-channel boot-wait sequencer gating lockstep enable until cores settle.
// all_done is registered from next-state done flags, so it rises with the last channel's done.
module ls_boot_seq
    import ls_safety_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 7,
    parameter int BOOT_WAIT  = 25,
    parameter int AUTO_START = 1,
    parameter int PERIODIC   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [2*NUM_CH-1:0]     clear_counter,
    input  logic [NUM_CH-1:0]       cfg_we,
    input  logic [CNT_W-1:0]        cfg_wdata,
    output logic [NUM_CH-1:0]       count_done,
    output logic [NUM_CH-1:0]       done_pulse,
    output logic                    all_done,
    output logic [NUM_CH*CNT_W-1:0] count_o
);

    logic [NUM_CH-1:0] done_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ls_boot_seq_ch #(
            .CNT_W      (CNT_W),
            .BOOT_WAIT  (BOOT_WAIT),
            .AUTO_START (AUTO_START),
            .PERIODIC   (PERIODIC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start      (start[i]),
            .ctl        (clear_counter[2*i +: 2]),
            .cfg_we     (cfg_we[i]),
            .cfg_wdata  (cfg_wdata),
            .count      (count_o[CNT_W*i +: CNT_W]),
            .count_done (count_done[i]),
            .done_pulse (done_pulse[i]),
            .done_nxt   (done_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_done <= 1'b0;
        end else begin
            all_done <= &done_nxt;
        end
    end

endmodule
